// File: rtl/ristretto_mem_arbiter.sv
// rtl/ristretto_mem_arbiter.sv - three-way (I/R/W) arbiter onto one single-outstanding memory bus
// Optional RISTRETTO_MEM_ARB_RR_EN selects round-robin instead of fixed priority with I starvation guard.
module ristretto_mem_arbiter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int StarveLimit = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   instr_req_i,
    input  logic [AddrWidth-1:0]   instr_addr_i,
    output logic                   instr_ready_o,
    output logic                   instr_valid_o,
    output logic [DataWidth-1:0]   instr_rdata_o,
    input  logic                   rdata_req_i,
    input  logic [AddrWidth-1:0]   rdata_addr_i,
    input  logic [DataWidth/8-1:0] rdata_strb_i,
    output logic                   rdata_ready_o,
    output logic                   rdata_valid_o,
    output logic [DataWidth-1:0]   rdata_data_o,
    input  logic                   wdata_req_i,
    input  logic [AddrWidth-1:0]   wdata_addr_i,
    input  logic [DataWidth-1:0]   wdata_data_i,
    input  logic [DataWidth/8-1:0] wdata_strb_i,
    output logic                   wdata_ready_o,
    output logic                   wdata_valid_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_strb_o,
    input  logic                   mem_ready_i,
    input  logic                   mem_valid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic [1:0]             arb_owner_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam logic [1:0] OwnNone = 2'd0;
    localparam logic [1:0] OwnI    = 2'd1;
    localparam logic [1:0] OwnR    = 2'd2;
    localparam logic [1:0] OwnW    = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [1:0]             winner;
    logic                   any_req, grant, accept, respond;
    logic [AddrWidth-1:0]   addr_q, lat_addr;
    logic [DataWidth-1:0]   wdata_q, lat_wdata;
    logic [StrbWidth-1:0]   strb_q, lat_strb;
    logic                   we_q, lat_we;

    assign any_req = instr_req_i | rdata_req_i | wdata_req_i;
    assign grant   = (state_q == IDLE) && any_req;
    assign accept  = (state_q == REQ) && mem_ready_i;
    assign respond = (state_q == RESP) && mem_valid_i;

`ifdef RISTRETTO_MEM_ARB_RR_EN
    // rr_ptr_q holds the owner code that has top priority at the next arbitration
    logic [1:0] rr_ptr_q;

    always_comb begin
        winner = OwnNone;
        case (rr_ptr_q)
            OwnR: begin
                if (rdata_req_i)      winner = OwnR;
                else if (wdata_req_i) winner = OwnW;
                else if (instr_req_i) winner = OwnI;
            end
            OwnW: begin
                if (wdata_req_i)      winner = OwnW;
                else if (instr_req_i) winner = OwnI;
                else if (rdata_req_i) winner = OwnR;
            end
            default: begin
                if (instr_req_i)      winner = OwnI;
                else if (rdata_req_i) winner = OwnR;
                else if (wdata_req_i) winner = OwnW;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_q <= OwnI;
        end else if (grant) begin
            rr_ptr_q <= (winner == OwnW) ? OwnI : winner + 2'd1;
        end
    end
`else
    localparam logic [3:0] StarveMax = 4'(StarveLimit);
    logic [3:0] starve_q;
    logic       force_i;

    assign force_i = instr_req_i && (starve_q == StarveMax);

    always_comb begin
        winner = OwnNone;
        if (force_i)          winner = OwnI;
        else if (rdata_req_i) winner = OwnR;
        else if (wdata_req_i) winner = OwnW;
        else if (instr_req_i) winner = OwnI;
    end

    // Counts arbitrations I lost while requesting; saturates at the limit
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_q <= 4'd0;
        end else if (grant && instr_req_i) begin
            if (winner == OwnI)            starve_q <= 4'd0;
            else if (starve_q != StarveMax) starve_q <= starve_q + 4'd1;
        end
    end
`endif

    always_comb begin
        lat_addr  = '0;
        lat_wdata = '0;
        lat_strb  = '0;
        lat_we    = 1'b0;
        case (winner)
            OwnI: begin
                lat_addr = instr_addr_i;
                lat_strb = '1;
            end
            OwnR: begin
                lat_addr = rdata_addr_i;
                lat_strb = rdata_strb_i;
            end
            OwnW: begin
                lat_addr  = wdata_addr_i;
                lat_wdata = wdata_data_i;
                lat_strb  = wdata_strb_i;
                lat_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = REQ;
                owner_d = winner;
            end
            REQ: if (mem_ready_i) state_d = RESP;
            RESP: if (mem_valid_i) begin
                state_d = IDLE;
                owner_d = OwnNone;
            end
            default: begin
                state_d = IDLE;
                owner_d = OwnNone;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            owner_q <= OwnNone;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (grant) begin
                addr_q  <= lat_addr;
                wdata_q <= lat_wdata;
                strb_q  <= lat_strb;
                we_q    <= lat_we;
            end
        end
    end

    // Bus payload is only presented while a request is outstanding
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = mem_req_o ? addr_q  : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;
    assign mem_strb_o  = mem_req_o ? strb_q  : '0;
    assign arb_owner_o = owner_q;

    assign instr_ready_o = accept && (owner_q == OwnI);
    assign rdata_ready_o = accept && (owner_q == OwnR);
    assign wdata_ready_o = accept && (owner_q == OwnW);
    assign instr_valid_o = respond && (owner_q == OwnI);
    assign rdata_valid_o = respond && (owner_q == OwnR);
    assign wdata_valid_o = respond && (owner_q == OwnW);
    assign instr_rdata_o = instr_valid_o ? mem_rdata_i : '0;
    assign rdata_data_o  = rdata_valid_o ? mem_rdata_i : '0;

endmodule
